// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: MEM/WB field widths, register-field slices, MEM-stage FSM states.
package mips_pkg;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int RRR_W  = 15;

    localparam int RS_MSB = 14;
    localparam int RS_LSB = 10;
    localparam int RT_MSB = 9;
    localparam int RT_LSB = 5;
    localparam int RD_MSB = 4;
    localparam int RD_LSB = 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;
endpackage

// File: rtl/data_ram.sv
// Single-port synchronous data RAM, one 32-bit word per address, registered read.
module data_ram
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [DATA_W-1:0]              wdata,
    output logic [DATA_W-1:0]              rdata
);
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Read returns the pre-write contents on a same-address write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory access with wait states, MEM/WB register and stall request.
//
// state | meaning
// IDLE  | accepting; non-memory ops and misaligned accesses complete at the next edge
// BUSY  | multi-cycle access in flight; counter runs down to the completion cycle
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite_in,
    input  logic [DATA_W-1:0] ALU_Result_in,
    input  logic [DATA_W-1:0] ReadData2_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              MemToReg_in,
    input  logic              RegDest_in,
    input  logic [RRR_W-1:0]  rs_rt_rd_in,
    output logic              stall_out,
    output logic              RegWrite_wb,
    output logic              MemToReg_wb,
    output logic [DATA_W-1:0] MemData_wb,
    output logic [DATA_W-1:0] ALU_Result_wb,
    output logic [REG_W-1:0]  WriteReg_wb,
    output logic              misalign_err,
    output logic              illegal_op
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = (MEM_LATENCY > 1) ? CW'(MEM_LATENCY - 2) : '0;

    mem_state_t        state, stateNext;
    logic [CW-1:0]     cnt, cntNext;
    logic              complete;
    logic              stallReq;
    logic              memReq, misaligned, memAccess, isLoad, bothOps;
    logic              loadValid;
    logic              ramWe;
    logic [DATA_W-1:0] ramRdata;
    logic [REG_W-1:0]  writeReg;
    logic              unusedRs;

    assign memReq     = MemRead_in | MemWrite_in;
    assign misaligned = memReq & (ALU_Result_in[1:0] != 2'b00);
    assign memAccess  = memReq & ~misaligned;
    assign bothOps    = MemRead_in & MemWrite_in;
    assign isLoad     = MemRead_in & ~MemWrite_in;
    assign writeReg   = RegDest_in ? rs_rt_rd_in[RD_MSB:RD_LSB] : rs_rt_rd_in[RT_MSB:RT_LSB];
    assign unusedRs   = ^rs_rt_rd_in[RS_MSB:RS_LSB];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        complete  = 1'b0;
        stallReq  = 1'b0;
        case (state)
            IDLE: begin
                if (!memAccess || MEM_LATENCY == 1) begin
                    complete = 1'b1;
                end else begin
                    stateNext = BUSY;
                    cntNext   = CNT_INIT;
                    stallReq  = 1'b1;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    complete  = 1'b1;
                    stateNext = IDLE;
                end else begin
                    cntNext  = cnt - CW'(1);
                    stallReq = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    // Gated so an accept cycle seen while reset is held never stalls the front end.
    assign stall_out = stallReq & reset;

    assign ramWe = complete & memAccess & MemWrite_in;

    data_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_data_ram (
        .clk  (clk),
        .we   (ramWe),
        .addr (ALU_Result_in[AW+1:2]),
        .wdata(ReadData2_in),
        .rdata(ramRdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite_wb   <= 1'b0;
            MemToReg_wb   <= 1'b0;
            ALU_Result_wb <= '0;
            WriteReg_wb   <= '0;
            loadValid     <= 1'b0;
            misalign_err  <= 1'b0;
            illegal_op    <= 1'b0;
        end else if (complete) begin
            RegWrite_wb   <= RegWrite_in & ~misaligned & ~bothOps;
            MemToReg_wb   <= MemToReg_in;
            ALU_Result_wb <= ALU_Result_in;
            WriteReg_wb   <= writeReg;
            loadValid     <= isLoad & memAccess;
            misalign_err  <= misaligned;
            illegal_op    <= bothOps;
        end else begin
            RegWrite_wb   <= 1'b0;
            MemToReg_wb   <= 1'b0;
            ALU_Result_wb <= '0;
            WriteReg_wb   <= '0;
            loadValid     <= 1'b0;
            misalign_err  <= 1'b0;
            illegal_op    <= 1'b0;
        end
    end

    // RAM output register holds the word read at the completion edge; masked to 0 otherwise.
    assign MemData_wb = loadValid ? ramRdata : '0;
endmodule
